// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs a req/ack fetch and computes the next PC on commit.
// Optional misaligned-target trap enabled by defining IFU_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_commit,
  input  logic [2:0]  i_npc_sel,
  input  logic        i_zero,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_align_fault
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
`ifdef IFU_ALIGN_CHECK_EN
  localparam logic [1:0] ST_FAULT = 2'd3;
`endif

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BEQ  = 3'b001;
  localparam logic [2:0] SEL_JUMP = 3'b010;
  localparam logic [2:0] SEL_JR   = 3'b011;
  localparam logic [2:0] SEL_BNE  = 3'b100;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  function automatic logic [31:0] f_branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] f_next_pc(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] rs,
    input logic [2:0]  sel,
    input logic        zero
  );
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    case (sel)
      SEL_SEQ:  return pc4;
      SEL_BEQ:  return zero ? f_branch_target(pc4, instr[15:0]) : pc4;
      SEL_JUMP: return {pc4[31:28], instr[25:0], 2'b00};
      SEL_JR:   return rs;
      SEL_BNE:  return zero ? pc4 : f_branch_target(pc4, instr[15:0]);
      default:  return pc4;
    endcase
  endfunction

  // Raw target from the decoder select; the sequential path decides whether it is usable.
  always_comb begin
    w_target  = f_next_pc(r_pc, r_instr, i_rs_data, i_npc_sel, i_zero);
    w_next_pc = w_target & ~32'd3;
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic r_align_fault;
  logic w_misaligned;

  // A target with low bits set is trapped rather than silently realigned.
  always_comb begin
    w_misaligned = (w_target[1:0] != 2'b00);
  end
`endif

  // Fetch/execute sequencer; reset wins over any pending ack or commit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_pc_plus4    <= RESET_PC + 32'd4;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      r_align_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (i_imem_ack) begin
            r_instr       <= i_imem_rdata;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (i_commit) begin
`ifdef IFU_ALIGN_CHECK_EN
            if (w_misaligned) begin
              r_state       <= ST_FAULT;
              r_instr_valid <= 1'b0;
              r_align_fault <= 1'b1;
            end else begin
              r_pc          <= w_next_pc;
              r_pc_plus4    <= w_next_pc + 32'd4;
              r_instr_valid <= 1'b0;
              r_imem_req    <= 1'b1;
              r_state       <= ST_REQ;
            end
`else
            r_pc          <= w_next_pc;
            r_pc_plus4    <= w_next_pc + 32'd4;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= ST_REQ;
`endif
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        ST_FAULT: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
`endif
        default: begin
          r_state       <= ST_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc_plus4;
`ifdef IFU_ALIGN_CHECK_EN
  assign o_align_fault = r_align_fault;
`else
  assign o_align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural model compared every cycle plus directed literals.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, ack, commit, zero;
  logic [31:0] rdata, rs;
  logic [2:0]  sel;
  logic        o_imem_req, o_instr_valid, o_align_fault;
  logic [31:0] o_imem_addr, o_instr, o_pc, o_pc_plus4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_reset(reset),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_instr(o_instr), .o_instr_valid(o_instr_valid),
    .i_commit(commit), .i_npc_sel(sel), .i_zero(zero), .i_rs_data(rs),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_align_fault(o_align_fault)
  );

  // ---------------- behavioural model ----------------
  logic        m_known = 1'b0;
  logic        m_boot, m_req, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_t;

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [2:0] s, input logic z, input logic [31:0] r);
    logic [31:0] seq, br;
    seq = pc + 32'd4;
    br  = seq + 32'($signed(ins[15:0])) * 32'd4;
    if (s == 3'd1) return z ? br : seq;
    if (s == 3'd2) return (seq & 32'hF000_0000) | (32'(ins[25:0]) << 2);
    if (s == 3'd3) return r;
    if (s == 3'd4) return z ? seq : br;
    return seq;
  endfunction

  always_comb m_t = model_target(m_pc, m_instr, sel, zero, rs);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_known <= 1'b1; m_boot <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0;
      m_fault <= 1'b0; m_pc <= RST_PC; m_instr <= 32'd0;
    end else if (m_known) begin
      if (m_boot) begin
        m_boot <= 1'b0; m_req <= 1'b1;
      end else if (m_req && ack) begin
        m_instr <= rdata; m_req <= 1'b0; m_valid <= 1'b1;
      end else if (m_valid && commit) begin
        m_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        if (m_t[1:0] != 2'b00) begin
          m_fault <= 1'b1;
        end else begin
          m_pc <= m_t; m_req <= 1'b1;
        end
`else
        m_pc <= {m_t[31:2], 2'b00}; m_req <= 1'b1;
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc", o_pc, m_pc);
      chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
      chk("imem_addr", o_imem_addr, m_pc);
      chk("instr", o_instr, m_instr);
      chk("instr_valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
      chk("imem_req", {31'd0, o_imem_req}, {31'd0, m_req});
      chk("align_fault", {31'd0, o_align_fault}, {31'd0, m_fault});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; commit = 1'b0; ack = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic fetch(input logic [31:0] w, input int waits);
    int n = 0;
    while (!m_req && n < 20) begin step(); n++; end
    if (!m_req) chk("fetch_timeout", 32'd0, 32'd1);
    repeat (waits) step();
    ack = 1'b1; rdata = w;
    step();
    ack = 1'b0; rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_commit(input logic [2:0] s, input logic z, input logic [31:0] r);
    if (!m_valid) chk("commit_not_exec", 32'd0, 32'd1);
    commit = 1'b1; sel = s; zero = z; rs = r;
    step();
    commit = 1'b0; sel = 3'b011; zero = ~z; rs = 32'hBAD0_0001;
  endtask

  initial begin
    int t1, t2;
    reset = 1'b1; ack = 1'b0; commit = 1'b0; zero = 1'b0;
    rdata = 32'd0; rs = 32'd0; sel = 3'd0;

    // Reset state
    do_reset();
    chk("rst_pc", o_pc, 32'h0000_3000);
    chk("rst_pc4", o_pc_plus4, 32'h0000_3004);
    chk("rst_instr", o_instr, 32'd0);

    // Sequential fetch, zero wait, one instruction per 2 cycles
    chk("seq_addr0", o_imem_addr, 32'h0000_3000);
    fetch(32'h0000_0001, 0); t1 = cyc;
    do_commit(3'd0, 1'b0, 32'd0);
    chk("seq_addr1", o_imem_addr, 32'h0000_3004);
    fetch(32'h0000_0002, 0); t2 = cyc;
    chk("throughput", 32'(t2 - t1), 32'd2);
    do_commit(3'd0, 1'b0, 32'd0);
    chk("seq_addr2", o_imem_addr, 32'h0000_3008);

    // BEQ backward, taken and not taken, from 0x3010
    fetch(32'h0000_0003, 0); do_commit(3'd0, 1'b0, 32'd0);
    fetch(32'h0000_0004, 0); do_commit(3'd0, 1'b0, 32'd0);
    chk("at_3010", o_pc, 32'h0000_3010);
    fetch(32'h1000_FFFE, 0); do_commit(3'd1, 1'b1, 32'd0);
    chk("beq_taken", o_pc, 32'h0000_300C);
    fetch(32'h0000_0000, 0); do_commit(3'd3, 1'b0, 32'h0000_3010);
    fetch(32'h1000_FFFE, 0); do_commit(3'd1, 1'b0, 32'd0);
    chk("beq_not_taken", o_pc, 32'h0000_3014);

    // BNE forward
    do_reset();
    fetch(32'h1400_0003, 0); do_commit(3'd4, 1'b0, 32'd0);
    chk("bne_taken", o_pc, 32'h0000_3010);
    fetch(32'h0000_0000, 0); do_commit(3'd3, 1'b0, 32'h0000_3000);
    fetch(32'h1400_0003, 0); do_commit(3'd4, 1'b1, 32'd0);
    chk("bne_not_taken", o_pc, 32'h0000_3004);

    // J with link value, plus ack ignored in EXEC
    do_reset();
    fetch(32'h0800_0C10, 0);
    chk("j_link", o_pc_plus4, 32'h0000_3004);
    ack = 1'b1; rdata = 32'h1234_5678; step(); ack = 1'b0;
    chk("ack_ignored_exec", o_instr, 32'h0800_0C10);
    do_commit(3'd2, 1'b0, 32'd0);
    chk("j_target", o_pc, 32'h0000_3040);
    commit = 1'b1; sel = 3'd3; rs = 32'h0000_5000; step(); commit = 1'b0;
    chk("commit_ignored_req", o_pc, 32'h0000_3040);

    // PC wrap is silent
    fetch(32'h0, 0); do_commit(3'd3, 1'b0, 32'hFFFF_FFFC);
    fetch(32'h0, 0); do_commit(3'd0, 1'b0, 32'd0);
    chk("pc_wrap", o_pc, 32'h0000_0000);

    // Delayed ack: address stable, no valid
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_addr", o_imem_addr, 32'h0000_3000);
      chk("wait_valid", {31'd0, o_instr_valid}, 32'd0);
    end
    fetch(32'h0000_00AA, 0);
    chk("late_instr", o_instr, 32'h0000_00AA);

    // Reset on the 3rd wait cycle of a REQ
    do_commit(3'd3, 1'b0, 32'h0000_3100);
    step(); step();
    reset = 1'b1; ack = 1'b1; step(); reset = 1'b0; ack = 1'b0;
    chk("rst_mid_req_pc", o_pc, 32'h0000_3000);
    chk("rst_mid_req_req", {31'd0, o_imem_req}, 32'd0);
    step();

    // Reset overrides a commit in EXEC
    fetch(32'h0, 0); do_commit(3'd3, 1'b0, 32'h0000_3200);
    fetch(32'h0, 0);
    commit = 1'b1; sel = 3'd3; rs = 32'h0000_4000; reset = 1'b1;
    step(); commit = 1'b0; reset = 1'b0;
    chk("rst_mid_exec_pc", o_pc, 32'h0000_3000);
    step();

    // Misaligned JR target
    fetch(32'h0, 0); do_commit(3'd3, 1'b0, 32'h0000_3002);
`ifdef IFU_ALIGN_CHECK_EN
    chk("align_fault", {31'd0, o_align_fault}, 32'd1);
    chk("align_pc_held", o_pc, 32'h0000_3000);
    repeat (4) step();
    chk("align_no_req", {31'd0, o_imem_req}, 32'd0);
`else
    chk("align_forced", o_pc, 32'h0000_3000);
    chk("align_flag_zero", {31'd0, o_align_fault}, 32'd0);
    repeat (2) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
